// File: rtl/button_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : button_event_ctrl
// Purpose  : Converts the clean, clk-synchronous level coming out of a button
//            debouncer into single-cycle control events for the clock
//            time-set logic: press, short release, long press, auto-repeat
//            while held, and release. One instance per button.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LONG_CYCLES   : cycles the button must stay held after the press pulse
//                   before the long-press event fires (min 2)
//   REPEAT_CYCLES : auto-repeat period while in the held state (min 2)
//   CNT_W         : counter width, 2**CNT_W > max(LONG_CYCLES, REPEAT_CYCLES)
// Ports
//   clk           : in  - system clock, rising edge
//   rst           : in  - asynchronous reset, active low
//   btn           : in  - debounced button level, synchronous to clk
//   rpt_en        : in  - enables auto-repeat pulses while held
//   press_pulse   : out - one-cycle pulse on a new press
//   short_pulse   : out - one-cycle pulse on release before long threshold
//   long_pulse    : out - one-cycle pulse when the long threshold is reached
//   repeat_pulse  : out - one-cycle auto-repeat pulse
//   release_pulse : out - one-cycle pulse on any release after a press
//   held          : out - level, high while the button counts as pressed
// ============================================================================
module button_event_ctrl #(
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000,
    parameter int CNT_W         = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic rpt_en,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic release_pulse,
    output logic held
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;

    // Terminal counts: the counter runs 0..N-1, so the event fires on the
    // N-th qualifying edge after the counter was cleared.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------------
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             btn_prev;
    logic             rise;
    logic             long_hit;
    logic             repeat_hit;

    logic             press_nxt;
    logic             short_nxt;
    logic             long_nxt;
    logic             repeat_nxt;
    logic             release_nxt;
    logic             held_nxt;

    // btn_prev resets to 1 so a button already down when reset releases
    // produces no rising edge; it has to go up and down again first.
    assign rise       = btn & ~btn_prev;
    assign long_hit   = (cnt == LONG_LAST);
    assign repeat_hit = (cnt == REPEAT_LAST);

    // ------------------------------------------------------------------------
    // State register (state, counter, edge-detect history)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            btn_prev <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            btn_prev <= btn;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and counter logic
    // A low button is tested before any threshold so that a release on the
    // threshold edge wins over the long/repeat event.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (rise) begin
                    state_nxt = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (!btn) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (long_hit) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!btn) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (!rpt_en) begin
                    // Gated repeat restarts a full period once re-enabled.
                    cnt_nxt   = '0;
                end else if (repeat_hit) begin
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode: values the output registers take on this edge
    // ------------------------------------------------------------------------
    always_comb begin
        press_nxt   = 1'b0;
        short_nxt   = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        release_nxt = 1'b0;
        held_nxt    = (state_nxt != ST_IDLE);
        case (state)
            ST_IDLE: begin
                press_nxt = rise;
            end
            ST_PRESSED: begin
                if (!btn) begin
                    short_nxt   = 1'b1;
                    release_nxt = 1'b1;
                end else begin
                    long_nxt    = long_hit;
                end
            end
            ST_HELD: begin
                if (!btn) begin
                    release_nxt = 1'b1;
                end else begin
                    repeat_nxt  = rpt_en & repeat_hit;
                end
            end
            default: begin
                held_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output registers: every event is a clean one-cycle registered pulse,
    // cleared asynchronously by reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_pulse   <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            held          <= 1'b0;
        end else begin
            press_pulse   <= press_nxt;
            short_pulse   <= short_nxt;
            long_pulse    <= long_nxt;
            repeat_pulse  <= repeat_nxt;
            release_pulse <= release_nxt;
            held          <= held_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_ctrl
// Purpose  : Self-checking bench for button_event_ctrl (LONG=8, REPEAT=4).
//            A behavioural model tracks press age and held time; outputs
//            are compared against it every cycle, and directed scenarios pin
//            pulse timing with hand-computed cycle masks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_ctrl;

    localparam int LONG = 8;
    localparam int REP  = 4;
    localparam int CW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn = 1'b1;
    logic rpt_en = 1'b1;
    logic press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held;

    int n_checks = 0;
    int n_pass   = 0;

    button_event_ctrl #(
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (REP),
        .CNT_W         (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn           (btn),
        .rpt_en        (rpt_en),
        .press_pulse   (press_pulse),
        .short_pulse   (short_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .release_pulse (release_pulse),
        .held          (held)
    );

    always #5 clk = ~clk;

    logic [5:0] dut_v;
    assign dut_v = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held};

    // ------------------------------------------------------------------------
    // Behavioural model: phase 0 = idle, 1 = pressed, 2 = held.
    // m_age counts edges since the press (or since the last long/repeat
    // event or repeat gating) and events fire when it reaches the period.
    // ------------------------------------------------------------------------
    int         m_phase = 0;
    int         m_age   = 0;
    logic       m_prev  = 1'b1;
    logic [5:0] exp_v   = 6'd0;

    initial begin
        logic p, s, l, r, rl;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_phase = 0;
                m_age   = 0;
                m_prev  = 1'b1;
                exp_v   = 6'd0;
            end else begin
                p = 0; s = 0; l = 0; r = 0; rl = 0;
                case (m_phase)
                    0: if (btn && !m_prev) begin
                        m_phase = 1;
                        m_age   = 0;
                        p       = 1;
                    end
                    1: begin
                        m_age = m_age + 1;
                        if (!btn) begin
                            s = 1; rl = 1; m_phase = 0;
                        end else if (m_age == LONG) begin
                            l = 1; m_phase = 2; m_age = 0;
                        end
                    end
                    default: begin
                        if (!btn) begin
                            rl = 1; m_phase = 0;
                        end else if (!rpt_en) begin
                            m_age = 0;
                        end else begin
                            m_age = m_age + 1;
                            if (m_age == REP) begin
                                r = 1; m_age = 0;
                            end
                        end
                    end
                endcase
                m_prev = btn;
                exp_v  = {p, s, l, r, rl, (m_phase != 0)};
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                n_checks++;
                if (dut_v !== exp_v)
                    $display("FAIL model_cmp t=%0t: got %b expected %b (press,short,long,rep,rel,held)",
                             $time, dut_v, exp_v);
                else
                    n_pass++;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed-test helpers: record which relative cycles each output is high
    // ------------------------------------------------------------------------
    int          k;
    logic [63:0] r_press, r_short, r_long, r_rep, r_rel, r_held;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", name, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [63:0] bits(input int lo, input int hi);
        logic [63:0] m;
        m = 64'd0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] b1(input int i);
        return 64'd1 << i;
    endfunction

    task automatic clear_rec();
        k = 0;
        r_press = 0; r_short = 0; r_long = 0; r_rep = 0; r_rel = 0; r_held = 0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        k++;
        if (k < 64) begin
            r_press[k] = press_pulse;
            r_short[k] = short_pulse;
            r_long[k]  = long_pulse;
            r_rep[k]   = repeat_pulse;
            r_rel[k]   = release_pulse;
            r_held[k]  = held;
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int run_left;
        clear_rec();

        // Reset lockout: button held through reset release.
        chk("reset_outputs", 64'(dut_v), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        clear_rec();
        cycles(20); btn = 1'b0;
        cycles(5);  btn = 1'b1;
        cycles(3);  btn = 1'b0;
        cycles(4);
        chk("lockout_press",   r_press, b1(26));
        chk("lockout_short",   r_short, b1(29));
        chk("lockout_release", r_rel,   b1(29));
        chk("lockout_held",    r_held,  bits(26, 28));
        chk("lockout_long",    r_long | r_rep, 64'd0);

        // Short press.
        clear_rec(); btn = 1'b1;
        cycles(5);   btn = 1'b0;
        cycles(4);
        chk("short_press",   r_press, b1(1));
        chk("short_short",   r_short, b1(6));
        chk("short_release", r_rel,   b1(6));
        chk("short_held",    r_held,  bits(1, 5));
        chk("short_long",    r_long,  64'd0);

        // Long press with repeat.
        rpt_en = 1'b1;
        clear_rec(); btn = 1'b1;
        cycles(30);  btn = 1'b0;
        cycles(4);
        chk("long_press",   r_press, b1(1));
        chk("long_long",    r_long,  b1(9));
        chk("long_repeat",  r_rep,   b1(13) | b1(17) | b1(21) | b1(25) | b1(29));
        chk("long_release", r_rel,   b1(31));
        chk("long_short",   r_short, 64'd0);
        chk("long_held",    r_held,  bits(1, 30));

        // Repeat gating.
        clear_rec(); btn = 1'b1;
        cycles(10);  rpt_en = 1'b0;
        cycles(10);  rpt_en = 1'b1;
        cycles(10);  btn = 1'b0;
        cycles(4);
        chk("gate_long",    r_long, b1(9));
        chk("gate_repeat",  r_rep,  b1(24) | b1(28));
        chk("gate_release", r_rel,  b1(31));

        // Release on the long-threshold edge.
        clear_rec(); btn = 1'b1;
        cycles(8);   btn = 1'b0;
        cycles(4);
        chk("thr_short",   r_short, b1(9));
        chk("thr_release", r_rel,   b1(9));
        chk("thr_long",    r_long,  64'd0);
        chk("thr_held",    r_held,  bits(1, 8));

        // Asynchronous reset mid-HELD.
        clear_rec(); btn = 1'b1;
        cycles(12);
        chk("async_held_before", 64'(held), 64'd1);
        #3 rst = 1'b0;
        #1 chk("async_clear", 64'(dut_v), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_rec();
        cycles(10); btn = 1'b0;
        cycles(3);  btn = 1'b1;
        cycles(3);  btn = 1'b0;
        cycles(4);
        chk("async_press",   r_press, b1(14));
        chk("async_short",   r_short, b1(17));
        chk("async_release", r_rel,   b1(17));
        chk("async_held",    r_held,  bits(14, 16));
        chk("async_long",    r_long | r_rep, 64'd0);

        // Randomized phase checked by the model.
        run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (run_left == 0) begin
                btn = ~btn;
                if ($urandom_range(0, 3) == 0) run_left = $urandom_range(15, 40);
                else                           run_left = $urandom_range(1, 12);
            end
            run_left--;
            if ($urandom_range(0, 15) == 0) rpt_en = ~rpt_en;
            if ($urandom_range(0, 399) == 0) begin
                #($urandom_range(1, 4)) rst = 1'b0;
                #1 chk("rand_async_clear", 64'(dut_v), 64'd0);
                @(negedge clk);
                rst = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
